// File: rtl/algo_nr1w_repl_pkg.sv
// Shared types and helpers for the replicated N-read / 1-write memory wrapper.
package algo_nr1w_repl_pkg;

    // Controller states: walk every address writing INITVAL, then serve users.
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Widest word the parity helper accepts; callers zero-extend into it,
    // which leaves the XOR unchanged.
    localparam int PAR_MAXW = 1024;

    function automatic logic calc_par(input logic [PAR_MAXW-1:0] d);
        return ^d;
    endfunction

    // Cycles from a sampled user read to its rd_vld pulse.
    function automatic int calc_rdlat(input int flopin, input int sram_delay, input int flopout);
        return flopin + sram_delay + flopout;
    endfunction

endpackage

// File: rtl/algo_nr1w_repl_if.sv
// User-side and bank-side signal bundle of the replicated memory wrapper.
// The slave modport is the wrapper; the master side owns the user requests
// and returns bank read data on t1_doutB.
interface algo_nr1w_repl_if #(
    parameter int WIDTH   = 64,
    parameter int NUMRDPT = 4,
    parameter int BITADDR = 13,
    parameter int PHYWDTH = 64
);
    logic                         ready;
    logic                         write;
    logic [BITADDR-1:0]           wr_adr;
    logic [WIDTH-1:0]             din;

    logic [NUMRDPT-1:0]           read;
    logic [NUMRDPT*BITADDR-1:0]   rd_adr;
    logic [NUMRDPT-1:0]           rd_vld;
    logic [NUMRDPT*WIDTH-1:0]     rd_dout;
    logic [NUMRDPT-1:0]           rd_serr;
    logic [NUMRDPT-1:0]           rd_derr;
    logic [NUMRDPT*BITADDR-1:0]   rd_padr;

    logic [NUMRDPT-1:0]           t1_writeA;
    logic [NUMRDPT*BITADDR-1:0]   t1_addrA;
    logic [NUMRDPT*PHYWDTH-1:0]   t1_dinA;
    logic [NUMRDPT-1:0]           t1_readB;
    logic [NUMRDPT*BITADDR-1:0]   t1_addrB;
    logic [NUMRDPT*PHYWDTH-1:0]   t1_doutB;

    modport master (
        input  ready, rd_vld, rd_dout, rd_serr, rd_derr, rd_padr,
        input  t1_writeA, t1_addrA, t1_dinA, t1_readB, t1_addrB,
        output write, wr_adr, din, read, rd_adr, t1_doutB
    );

    modport slave (
        output ready, rd_vld, rd_dout, rd_serr, rd_derr, rd_padr,
        output t1_writeA, t1_addrA, t1_dinA, t1_readB, t1_addrB,
        input  write, wr_adr, din, read, rd_adr, t1_doutB
    );
endinterface

// File: rtl/algo_nr1w_repl_rdpipe.sv
// One read port: range check and bank read issue, a valid/address/error
// delay line matching the bank latency, and an optional output register.
module algo_nr1w_repl_rdpipe
    import algo_nr1w_repl_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int PHYWDTH = 64,
    parameter int NUMADDR = 8192,
    parameter int BITADDR = 13,
    parameter int RDLAT   = 1,
    parameter int FLOPIN  = 0,
    parameter int FLOPOUT = 0,
    parameter int ENAPAR  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_i,
    input  logic [BITADDR-1:0] adr_i,
    input  logic [PHYWDTH-1:0] t1_dout_i,
    output logic               t1_read_o,
    output logic [BITADDR-1:0] t1_addr_o,
    output logic               rd_vld_o,
    output logic [WIDTH-1:0]   rd_dout_o,
    output logic               rd_serr_o,
    output logic               rd_derr_o,
    output logic [BITADDR-1:0] rd_padr_o
);

    // Bank latency: the part of the read latency not spent in the in/out flops.
    localparam int              DEPTH   = RDLAT - FLOPIN - FLOPOUT;
    localparam logic [BITADDR:0] ADR_LIM = (BITADDR+1)'(NUMADDR);

    logic                            in_rng;
    logic [DEPTH-1:0]                vld_q;
    logic [DEPTH-1:0]                derr_q;
    logic [DEPTH-1:0][BITADDR-1:0]   adr_q;

    logic                            vld_s;
    logic                            derr_s;
    logic                            serr_s;
    logic [WIDTH-1:0]                dout_s;
    logic [BITADDR-1:0]              padr_s;

    // Out-of-range requests never touch the bank but still answer with derr.
    assign in_rng    = ({1'b0, adr_i} < ADR_LIM);
    assign t1_read_o = req_i & in_rng;
    assign t1_addr_o = t1_read_o ? adr_i : '0;

    // Carry request tag alongside the bank access until its data returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            derr_q <= '0;
            adr_q  <= '0;
        end else begin
            vld_q[0]  <= req_i;
            derr_q[0] <= ~in_rng;
            adr_q[0]  <= adr_i;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k]  <= vld_q[k-1];
                derr_q[k] <= derr_q[k-1];
                adr_q[k]  <= adr_q[k-1];
            end
        end
    end

    // Form the response; everything is zeroed when there is no valid.
    always_comb begin
        vld_s  = vld_q[DEPTH-1];
        derr_s = vld_s & derr_q[DEPTH-1];
        dout_s = (vld_s && !derr_s) ? t1_dout_i[WIDTH-1:0] : '0;
        serr_s = (ENAPAR != 0) && vld_s && !derr_s && calc_par(PAR_MAXW'(t1_dout_i));
        padr_s = vld_s ? adr_q[DEPTH-1] : '0;
    end

    if (FLOPOUT != 0) begin : g_flopout
        logic               rd_vld_q;
        logic [WIDTH-1:0]   rd_dout_q;
        logic               rd_serr_q;
        logic               rd_derr_q;
        logic [BITADDR-1:0] rd_padr_q;

        // Output register stage for timing closure on the bank read path.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_vld_q  <= 1'b0;
                rd_dout_q <= '0;
                rd_serr_q <= 1'b0;
                rd_derr_q <= 1'b0;
                rd_padr_q <= '0;
            end else begin
                rd_vld_q  <= vld_s;
                rd_dout_q <= dout_s;
                rd_serr_q <= serr_s;
                rd_derr_q <= derr_s;
                rd_padr_q <= padr_s;
            end
        end

        assign rd_vld_o  = rd_vld_q;
        assign rd_dout_o = rd_dout_q;
        assign rd_serr_o = rd_serr_q;
        assign rd_derr_o = rd_derr_q;
        assign rd_padr_o = rd_padr_q;
    end else begin : g_direct
        assign rd_vld_o  = vld_s;
        assign rd_dout_o = dout_s;
        assign rd_serr_o = serr_s;
        assign rd_derr_o = derr_s;
        assign rd_padr_o = padr_s;
    end

endmodule

// File: rtl/algo_nr1w_repl_top_wrap.sv
// NUMRDPT-read / 1-write memory built from NUMRDPT replicated banks. Every
// write lands in all banks; bank i serves read port i. After reset the
// controller fills every address with INITVAL before raising ready.
// The bus interface instance must be parameterised with matching widths.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_INIT  | writing INITVAL to address cnt_q in all banks, users ignored
// ST_READY | init done, user reads/writes are served
module algo_nr1w_repl_top_wrap
    import algo_nr1w_repl_pkg::*;
#(
    parameter int               WIDTH      = 64,
    parameter int               NUMRDPT    = 4,
    parameter int               NUMADDR    = 8192,
    parameter int               BITADDR    = 13,
    parameter int               SRAM_DELAY = 1,
    parameter int               FLOPIN     = 0,
    parameter int               FLOPOUT    = 0,
    parameter int               ENAPAR     = 0,
    parameter logic [WIDTH-1:0] INITVAL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    algo_nr1w_repl_if.slave  bus
);

    localparam int               PHYWDTH  = WIDTH + ENAPAR;
    localparam int               RDLAT    = calc_rdlat(FLOPIN, SRAM_DELAY, FLOPOUT);
    localparam logic [BITADDR:0] ADR_LIM  = (BITADDR+1)'(NUMADDR);
    localparam logic [BITADDR-1:0] ADR_LAST = BITADDR'(NUMADDR - 1);

    state_e                      state_q, state_d;
    logic [BITADDR-1:0]          cnt_q, cnt_d;
    logic                        ready_w;

    logic                        wr_s;
    logic [BITADDR-1:0]          wr_adr_s;
    logic [WIDTH-1:0]            din_s;
    logic [NUMRDPT-1:0]          rd_s;
    logic [NUMRDPT*BITADDR-1:0]  rd_adr_s;

    logic                        init_wr;
    logic                        wr_ok;
    logic                        wr_en;
    logic [BITADDR-1:0]          wr_adr;
    logic [WIDTH-1:0]            wr_dat;
    logic [PHYWDTH-1:0]          wr_word;

    if (FLOPIN != 0) begin : g_flopin
        // Input register stage; requests seen while not ready are dropped here.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_s     <= 1'b0;
                wr_adr_s <= '0;
                din_s    <= '0;
                rd_s     <= '0;
                rd_adr_s <= '0;
            end else begin
                wr_s     <= bus.write & ready_w;
                wr_adr_s <= bus.wr_adr;
                din_s    <= bus.din;
                rd_s     <= bus.read & {NUMRDPT{ready_w}};
                rd_adr_s <= bus.rd_adr;
            end
        end
    end else begin : g_noflopin
        // Direct path from the user pins, still gated by ready.
        always_comb begin
            wr_s     = bus.write & ready_w;
            wr_adr_s = bus.wr_adr;
            din_s    = bus.din;
            rd_s     = bus.read & {NUMRDPT{ready_w}};
            rd_adr_s = bus.rd_adr;
        end
    end

    // State register and init address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: step through every address once, then stay ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + BITADDR'(1);
                if (cnt_q == ADR_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: init fill has the write port to itself; user writes only when
    // ready. The init strobe is masked by rst so the banks are quiet in reset.
    always_comb begin
        ready_w = (state_q == ST_READY);
        init_wr = (state_q == ST_INIT) && !rst;
        wr_ok   = wr_s && ({1'b0, wr_adr_s} < ADR_LIM);
        wr_en   = init_wr || wr_ok;
        wr_adr  = init_wr ? cnt_q : wr_adr_s;
        wr_dat  = init_wr ? INITVAL : din_s;
        wr_word = PHYWDTH'({calc_par(PAR_MAXW'(wr_dat)), wr_dat});
    end

    assign bus.ready     = ready_w;
    assign bus.t1_writeA = {NUMRDPT{wr_en}};
    assign bus.t1_addrA  = {NUMRDPT{wr_adr}};
    assign bus.t1_dinA   = {NUMRDPT{wr_word}};

    logic                t1_read_w [NUMRDPT];
    logic [BITADDR-1:0]  t1_addr_w [NUMRDPT];
    logic                rd_vld_w  [NUMRDPT];
    logic [WIDTH-1:0]    rd_dout_w [NUMRDPT];
    logic                rd_serr_w [NUMRDPT];
    logic                rd_derr_w [NUMRDPT];
    logic [BITADDR-1:0]  rd_padr_w [NUMRDPT];

    for (genvar p = 0; p < NUMRDPT; p++) begin : g_port
        algo_nr1w_repl_rdpipe #(
            .WIDTH   (WIDTH),
            .PHYWDTH (PHYWDTH),
            .NUMADDR (NUMADDR),
            .BITADDR (BITADDR),
            .RDLAT   (RDLAT),
            .FLOPIN  (FLOPIN),
            .FLOPOUT (FLOPOUT),
            .ENAPAR  (ENAPAR)
        ) u_rdpipe (
            .clk       (clk),
            .rst       (rst),
            .req_i     (rd_s[p]),
            .adr_i     (rd_adr_s[p*BITADDR +: BITADDR]),
            .t1_dout_i (bus.t1_doutB[p*PHYWDTH +: PHYWDTH]),
            .t1_read_o (t1_read_w[p]),
            .t1_addr_o (t1_addr_w[p]),
            .rd_vld_o  (rd_vld_w[p]),
            .rd_dout_o (rd_dout_w[p]),
            .rd_serr_o (rd_serr_w[p]),
            .rd_derr_o (rd_derr_w[p]),
            .rd_padr_o (rd_padr_w[p])
        );
    end

    // Pack per-port results back onto the flat bus vectors.
    always_comb begin
        bus.t1_readB = '0;
        bus.t1_addrB = '0;
        bus.rd_vld   = '0;
        bus.rd_dout  = '0;
        bus.rd_serr  = '0;
        bus.rd_derr  = '0;
        bus.rd_padr  = '0;
        for (int p = 0; p < NUMRDPT; p++) begin
            bus.t1_readB[p]                    = t1_read_w[p];
            bus.t1_addrB[p*BITADDR +: BITADDR] = t1_addr_w[p];
            bus.rd_vld[p]                      = rd_vld_w[p];
            bus.rd_dout[p*WIDTH +: WIDTH]      = rd_dout_w[p];
            bus.rd_serr[p]                     = rd_serr_w[p];
            bus.rd_derr[p]                     = rd_derr_w[p];
            bus.rd_padr[p*BITADDR +: BITADDR]  = rd_padr_w[p];
        end
    end

endmodule

// File: tb/tb_algo_nr1w_repl_top_wrap.sv
// Directed bench: 16-bit words, 4 read ports, 24 words, parity on,
// bank latency 1, output flop on. Banks are modelled as read-first RAMs.
module tb_algo_nr1w_repl_top_wrap;
    localparam int W  = 16;
    localparam int NP = 4;
    localparam int NA = 24;
    localparam int BA = 5;
    localparam int PW = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flip_req = 1'b0;
    int   checks = 0;
    int   errors = 0;

    algo_nr1w_repl_if #(.WIDTH(W), .NUMRDPT(NP), .BITADDR(BA), .PHYWDTH(PW)) bus ();

    algo_nr1w_repl_top_wrap #(
        .WIDTH(W), .NUMRDPT(NP), .NUMADDR(NA), .BITADDR(BA), .SRAM_DELAY(1),
        .FLOPIN(0), .FLOPOUT(1), .ENAPAR(1), .INITVAL(16'h0007)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [PW-1:0] mem    [NP][NA];
    logic [PW-1:0] dout_q [NP];

    always @(posedge clk) begin
        for (int b = 0; b < NP; b++) begin
            if (bus.t1_readB[b] && int'(bus.t1_addrB[b*BA +: BA]) < NA)
                dout_q[b] <= mem[b][int'(bus.t1_addrB[b*BA +: BA])];
            if (bus.t1_writeA[b] && int'(bus.t1_addrA[b*BA +: BA]) < NA)
                mem[b][int'(bus.t1_addrA[b*BA +: BA])] <= bus.t1_dinA[b*PW +: PW];
        end
        if (flip_req) mem[1][5][PW-1] <= ~mem[1][5][PW-1];
    end

    always_comb begin
        bus.t1_doutB = '0;
        for (int b = 0; b < NP; b++) bus.t1_doutB[b*PW +: PW] = dout_q[b];
    end

    task automatic test_reset;
        bus.read = 4'hF;
        bus.rd_adr = {4{5'd3}};
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus.ready); end
        checks++; if (bus.t1_writeA !== 4'h0) begin errors++; $display("FAIL rst_writeA got %h exp 0", bus.t1_writeA); end
        checks++; if (bus.t1_readB !== 4'h0) begin errors++; $display("FAIL rst_readB got %h exp 0", bus.t1_readB); end
        // release, run part of INIT, then reset again mid-fill
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (bus.t1_addrA !== 20'h0) begin errors++; $display("FAIL init0_addr got %h exp 0", bus.t1_addrA); end
        repeat (10) @(negedge clk);
        #1;
        checks++; if (bus.t1_addrA !== {4{5'd10}}) begin errors++; $display("FAIL init10_addr got %h exp %h", bus.t1_addrA, {4{5'd10}}); end
        rst = 1'b1; #1;
        checks++; if (bus.t1_writeA !== 4'h0) begin errors++; $display("FAIL midinit_rst_writeA got %h exp 0", bus.t1_writeA); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (bus.t1_writeA !== 4'hF) begin errors++; $display("FAIL restart_writeA got %h exp F", bus.t1_writeA); end
        checks++; if (bus.t1_addrA !== 20'h0) begin errors++; $display("FAIL restart_addr got %h exp 0", bus.t1_addrA); end
        checks++; if (bus.t1_dinA !== {4{17'h10007}}) begin errors++; $display("FAIL init_din got %h exp %h", bus.t1_dinA, {4{17'h10007}}); end
        for (int i = 1; i < NA; i++) begin
            @(negedge clk); #1;
            checks++; if (bus.t1_addrA !== {4{5'(i)}} || bus.t1_writeA !== 4'hF) begin
                errors++; $display("FAIL init_walk i=%0d got we=%h adr=%h", i, bus.t1_writeA, bus.t1_addrA); end
            checks++; if (bus.ready !== 1'b0 || bus.t1_readB !== 4'h0 || bus.rd_vld !== 4'h0) begin
                errors++; $display("FAIL init_quiet i=%0d got rdy=%b rb=%h vld=%h exp 0", i, bus.ready, bus.t1_readB, bus.rd_vld); end
        end
        bus.read = 4'h0;
        @(negedge clk); #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL ready_24 got %b exp 1", bus.ready); end
        checks++; if (bus.t1_writeA !== 4'h0) begin errors++; $display("FAIL ready_writeA got %h exp 0", bus.t1_writeA); end
        @(negedge clk); #1;
        checks++; if (bus.rd_vld !== 4'h0) begin errors++; $display("FAIL init_read_vld got %h exp 0", bus.rd_vld); end
    endtask

    task automatic test_write_read;
        @(negedge clk);
        bus.write = 1'b1; bus.wr_adr = 5'd7; bus.din = 16'hA5A5; #1;
        checks++; if (bus.t1_writeA !== 4'hF || bus.t1_addrA !== {4{5'd7}}) begin
            errors++; $display("FAIL wr_strobe got we=%h adr=%h exp F/%h", bus.t1_writeA, bus.t1_addrA, {4{5'd7}}); end
        checks++; if (bus.t1_dinA !== {4{17'h0A5A5}}) begin errors++; $display("FAIL wr_din got %h exp %h", bus.t1_dinA, {4{17'h0A5A5}}); end
        @(negedge clk);
        bus.write = 1'b0; bus.read = 4'hF; bus.rd_adr = {4{5'd7}}; #1;
        checks++; if (bus.t1_readB !== 4'hF || bus.t1_addrB !== {4{5'd7}}) begin
            errors++; $display("FAIL rd_issue got rb=%h adr=%h", bus.t1_readB, bus.t1_addrB); end
        @(negedge clk); bus.read = 4'h0; #1;
        checks++; if (bus.rd_vld !== 4'h0) begin errors++; $display("FAIL rd_early got %h exp 0", bus.rd_vld); end
        @(negedge clk); #1;
        checks++; if (bus.rd_vld !== 4'hF) begin errors++; $display("FAIL rd_vld got %h exp F", bus.rd_vld); end
        checks++; if (bus.rd_dout !== {4{16'hA5A5}}) begin errors++; $display("FAIL rd_dout got %h exp %h", bus.rd_dout, {4{16'hA5A5}}); end
        checks++; if (bus.rd_serr !== 4'h0 || bus.rd_derr !== 4'h0) begin errors++; $display("FAIL rd_err got s=%h d=%h exp 0", bus.rd_serr, bus.rd_derr); end
        checks++; if (bus.rd_padr !== {4{5'd7}}) begin errors++; $display("FAIL rd_padr got %h exp %h", bus.rd_padr, {4{5'd7}}); end
        @(negedge clk); #1;
        checks++; if (bus.rd_vld !== 4'h0 || bus.rd_dout !== 64'h0 || bus.rd_padr !== 20'h0) begin
            errors++; $display("FAIL rd_idle got vld=%h dout=%h padr=%h exp 0", bus.rd_vld, bus.rd_dout, bus.rd_padr); end
    endtask

    task automatic test_multi_addr;
        @(negedge clk);
        bus.write = 1'b1; bus.wr_adr = 5'd0; bus.din = 16'h8001; #1;
        checks++; if (bus.t1_dinA !== {4{17'h08001}}) begin errors++; $display("FAIL wr0_din got %h exp %h", bus.t1_dinA, {4{17'h08001}}); end
        @(negedge clk);
        bus.wr_adr = 5'd23; bus.din = 16'h0100; #1;
        checks++; if (bus.t1_dinA !== {4{17'h10100}}) begin errors++; $display("FAIL wr23_din got %h exp %h", bus.t1_dinA, {4{17'h10100}}); end
        @(negedge clk);
        bus.write = 1'b0; bus.read = 4'hF; bus.rd_adr = {5'd12, 5'd7, 5'd23, 5'd0};
        @(negedge clk); bus.read = 4'h0;
        @(negedge clk); #1;
        checks++; if (bus.rd_dout !== {16'h0007, 16'hA5A5, 16'h0100, 16'h8001}) begin
            errors++; $display("FAIL multi_dout got %h exp %h", bus.rd_dout, {16'h0007, 16'hA5A5, 16'h0100, 16'h8001}); end
        checks++; if (bus.rd_padr !== {5'd12, 5'd7, 5'd23, 5'd0} || bus.rd_serr !== 4'h0) begin
            errors++; $display("FAIL multi_padr got padr=%h serr=%h", bus.rd_padr, bus.rd_serr); end
    endtask

    task automatic test_same_cycle;
        @(negedge clk);
        bus.write = 1'b1; bus.wr_adr = 5'd7; bus.din = 16'h1234;
        bus.read = 4'hF; bus.rd_adr = {4{5'd7}}; #1;
        checks++; if (bus.t1_dinA !== {4{17'h11234}} || bus.t1_readB !== 4'hF) begin
            errors++; $display("FAIL same_issue got din=%h rb=%h", bus.t1_dinA, bus.t1_readB); end
        @(negedge clk); bus.write = 1'b0;
        @(negedge clk); bus.read = 4'h0; #1;
        checks++; if (bus.rd_vld !== 4'hF || bus.rd_dout !== {4{16'hA5A5}}) begin
            errors++; $display("FAIL same_old got vld=%h dout=%h exp F/%h", bus.rd_vld, bus.rd_dout, {4{16'hA5A5}}); end
        @(negedge clk); #1;
        checks++; if (bus.rd_vld !== 4'hF || bus.rd_dout !== {4{16'h1234}}) begin
            errors++; $display("FAIL same_new got vld=%h dout=%h exp F/%h", bus.rd_vld, bus.rd_dout, {4{16'h1234}}); end
        @(negedge clk); #1;
        checks++; if (bus.rd_vld !== 4'h0) begin errors++; $display("FAIL same_tail got %h exp 0", bus.rd_vld); end
    endtask

    task automatic test_range;
        @(negedge clk);
        bus.write = 1'b1; bus.wr_adr = 5'd30; bus.din = 16'hBEEF;
        bus.read = 4'b1101; bus.rd_adr = {5'd24, 5'd30, 5'd0, 5'd23}; #1;
        checks++; if (bus.t1_writeA !== 4'h0) begin errors++; $display("FAIL range_wr got %h exp 0", bus.t1_writeA); end
        checks++; if (bus.t1_readB !== 4'b0001) begin errors++; $display("FAIL range_rb got %b exp 0001", bus.t1_readB); end
        @(negedge clk); bus.write = 1'b0; bus.read = 4'h0;
        @(negedge clk); #1;
        checks++; if (bus.rd_vld !== 4'b1101 || bus.rd_derr !== 4'b1100) begin
            errors++; $display("FAIL range_flags got vld=%b derr=%b exp 1101/1100", bus.rd_vld, bus.rd_derr); end
        checks++; if (bus.rd_dout !== {48'h0, 16'h0100} || bus.rd_serr !== 4'h0) begin
            errors++; $display("FAIL range_dout got dout=%h serr=%h", bus.rd_dout, bus.rd_serr); end
        checks++; if (bus.rd_padr !== {5'd24, 5'd30, 5'd0, 5'd23}) begin
            errors++; $display("FAIL range_padr got %h exp %h", bus.rd_padr, {5'd24, 5'd30, 5'd0, 5'd23}); end
    endtask

    task automatic test_parity;
        @(negedge clk); flip_req = 1'b1;
        @(negedge clk); flip_req = 1'b0;
        bus.read = 4'b0011; bus.rd_adr = {5'd0, 5'd0, 5'd5, 5'd5};
        @(negedge clk); bus.read = 4'h0;
        @(negedge clk); #1;
        checks++; if (bus.rd_vld !== 4'b0011 || bus.rd_serr !== 4'b0010) begin
            errors++; $display("FAIL parity got vld=%b serr=%b exp 0011/0010", bus.rd_vld, bus.rd_serr); end
        checks++; if (bus.rd_dout !== {32'h0, 16'h0007, 16'h0007}) begin
            errors++; $display("FAIL parity_dout got %h", bus.rd_dout); end
    endtask

    task automatic test_back_to_back;
        logic [4:0]  adr_v [4] = '{5'd0, 5'd7, 5'd23, 5'd5};
        logic [15:0] exp_v [4] = '{16'h8001, 16'h1234, 16'h0100, 16'h0007};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
            if (i >= 2 && i < 6) begin
                checks++; if (bus.rd_vld !== 4'b1000 || bus.rd_dout !== {exp_v[i-2], 48'h0} || bus.rd_padr !== {adr_v[i-2], 15'h0} || bus.rd_serr !== 4'h0) begin
                    errors++; $display("FAIL b2b i=%0d got vld=%b dout=%h padr=%h exp dout %h", i, bus.rd_vld, bus.rd_dout, bus.rd_padr, exp_v[i-2]); end
            end
            if (i == 6) begin
                checks++; if (bus.rd_vld !== 4'h0) begin errors++; $display("FAIL b2b_tail got %h exp 0", bus.rd_vld); end
            end
            if (i < 4) begin
                bus.read = 4'b1000; bus.rd_adr = {adr_v[i], 15'h0};
            end else begin
                bus.read = 4'h0;
            end
        end
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        bus.read = 4'hF; bus.rd_adr = {4{5'd7}};
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.rd_vld !== 4'hF) begin errors++; $display("FAIL midop_stream got %h exp F", bus.rd_vld); end
        rst = 1'b1; #1;
        checks++; if (bus.rd_vld !== 4'h0 || bus.rd_dout !== 64'h0 || bus.ready !== 1'b0) begin
            errors++; $display("FAIL midop_rst got vld=%h dout=%h rdy=%b", bus.rd_vld, bus.rd_dout, bus.ready); end
        checks++; if (bus.t1_readB !== 4'h0 || bus.t1_writeA !== 4'h0) begin
            errors++; $display("FAIL midop_t1 got rb=%h we=%h exp 0", bus.t1_readB, bus.t1_writeA); end
        @(negedge clk); rst = 1'b0; bus.read = 4'h0; #1;
        checks++; if (bus.t1_addrA !== 20'h0 || bus.t1_writeA !== 4'hF) begin
            errors++; $display("FAIL midop_restart got we=%h adr=%h", bus.t1_writeA, bus.t1_addrA); end
        for (int i = 1; i < NA; i++) begin
            @(negedge clk); #1;
            checks++; if (bus.rd_vld !== 4'h0 || bus.ready !== 1'b0) begin
                errors++; $display("FAIL midop_stale i=%0d got vld=%h rdy=%b", i, bus.rd_vld, bus.ready); end
        end
        @(negedge clk); #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midop_ready got %b exp 1", bus.ready); end
        bus.read = 4'b0001; bus.rd_adr = {15'h0, 5'd7};
        @(negedge clk); bus.read = 4'h0;
        @(negedge clk); #1;
        checks++; if (bus.rd_vld !== 4'b0001 || bus.rd_dout !== {48'h0, 16'h0007}) begin
            errors++; $display("FAIL midop_reinit got vld=%b dout=%h exp 0001/0007", bus.rd_vld, bus.rd_dout); end
    endtask

    initial begin
        bus.write  = 1'b0;
        bus.wr_adr = '0;
        bus.din    = '0;
        bus.read   = '0;
        bus.rd_adr = '0;
        test_reset();
        test_write_read();
        test_multi_addr();
        test_same_cycle();
        test_range();
        test_parity();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
